// File: rtl/mem_pkg.sv
// Shared types and default sizing for the memory slave.
package mem_pkg;

  localparam int unsigned DefWidth     = 8;
  localparam int unsigned DefAddrWidth = 4;

  // Handshake FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StAck
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Word storage: one write port, one registered read port, asynchronous clear.
module mem_array import mem_pkg::*; #(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port; reset wipes every word.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value until the next read.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_slave.sv
// Valid/ready memory slave with a fixed number of wait states per transfer.
module mem_slave import mem_pkg::*; #(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  valid,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy,
  output logic                  prot_err
);

  localparam logic [3:0] WaitCnt = 4'(WAIT_CYCLES);

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [WIDTH-1:0]        wdata_q;
  logic                    ready_q;
  logic                    prot_err_q;
  logic                    commit;

  // Memory access happens on the same edge that enters ACK.
  assign commit = (state_q == StBusy) && (cnt_q == 4'd0);

  mem_array #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem_array (
    .clk   (clk),
    .res   (res),
    .we    (commit & wr_q),
    .waddr (addr_q),
    .wdata (wdata_q),
    .re    (commit & ~wr_q),
    .raddr (addr_q),
    .rdata (rdata)
  );

  // Handshake FSM: latch command, count wait states, pulse ready for one cycle.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      prot_err_q <= 1'b0;
    end else begin
      ready_q    <= 1'b0;
      prot_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (valid) begin
            wr_q    <= wr_rd;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt_q   <= WaitCnt;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          // Master dropped valid before seeing ready; flag it but finish the transfer.
          if (!valid) begin
            prot_err_q <= 1'b1;
          end
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= StAck;
            ready_q <= 1'b1;
          end
        end
        // ACK never accepts, which enforces a dead cycle between transfers.
        StAck: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign prot_err = prot_err_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_slave.sv
// Directed bench for mem_slave: one instance with 2 wait states, one with none.
module tb_mem_slave;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       res;
  logic       valid;
  logic       sel;    // 0: two-wait-state instance, 1: zero-wait-state instance
  logic       wr_rd;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       valid2, valid0;
  logic       ready2, busy2, perr2, ready0, busy0, perr0;
  logic [7:0] rdata2, rdata0;
  logic [7:0] rdata_s;

  assign valid2  = valid & ~sel;
  assign valid0  = valid & sel;
  assign rdata_s = sel ? rdata0 : rdata2;

  mem_slave #(.WIDTH(8), .ADDR_WIDTH(4), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .res(res), .valid(valid2), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
    .ready(ready2), .rdata(rdata2), .busy(busy2), .prot_err(perr2)
  );

  mem_slave #(.WIDTH(8), .ADDR_WIDTH(4), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .res(res), .valid(valid0), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
    .ready(ready0), .rdata(rdata0), .busy(busy0), .prot_err(perr0)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         rdy_cnt [2];
  int         perr_cnt [2];
  int         last_rdy_cyc;
  logic [7:0] model [2][16];
  logic [7:0] last_rd [2];
  logic [7:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ready2) rdy_cnt[0] <= rdy_cnt[0] + 1;
    if (ready0) rdy_cnt[1] <= rdy_cnt[1] + 1;
    if (perr2)  perr_cnt[0] <= perr_cnt[0] + 1;
    if (perr0)  perr_cnt[1] <= perr_cnt[1] + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain, 1: change addr/wdata after acceptance, 2: drop valid one cycle in BUSY
  task automatic xfer(input logic s, input logic wr, input logic [3:0] a,
                      input logic [7:0] d, input int mode);
    int         w;
    int         n;
    int         acc_n;
    logic       got;
    logic [7:0] e;
    w = s ? 0 : 2;
    @(negedge clk);
    sel   = s;
    wr_rd = wr;
    addr  = a;
    wdata = d;
    valid = 1'b1;
    // A slave still in ACK accepts one edge later.
    acc_n = (s ? busy0 : busy2) ? 2 : 1;
    e = 8'h00;
    if (wr) model[s][a] = d;
    else    exp_q.push_back(model[s][a]);
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == acc_n) begin
        if (mode == 1) begin
          addr  = a + 4'd1;
          wdata = 8'hFF;
        end
        if (mode == 2) valid = 1'b0;
      end
      if (mode == 2 && n == acc_n + 1) valid = 1'b1;
      got = s ? ready0 : ready2;
    end
    check("ready_seen", 32'(got), 32'd1);
    check("ready_latency", 32'(n), 32'(acc_n + w + 1));
    if (!wr) begin
      e = exp_q.pop_front();
      check("rdata", 32'(rdata_s), 32'(e));
      last_rd[s] = e;
    end else begin
      check("rdata_hold", 32'(rdata_s), 32'(last_rd[s]));
    end
    last_rdy_cyc = cyc;
    valid = 1'b0;
  endtask

  initial begin
    int r1;
    int r0;
    int p0;
    res = 1'b1; valid = 1'b0; sel = 1'b0; wr_rd = 1'b0; addr = '0; wdata = '0;
    rdy_cnt  = '{0, 0};
    perr_cnt = '{0, 0};
    last_rd  = '{8'h00, 8'h00};
    for (int i = 0; i < 16; i++) begin
      model[0][i] = 8'h00;
      model[1][i] = 8'h00;
    end
    #2 res = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready2), 32'd0);
    check("rst_busy", 32'(busy2), 32'd0);
    check("rst_prot_err", 32'(perr2), 32'd0);
    check("rst_rdata", 32'(rdata2), 32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);
    @(negedge clk) res = 1'b1;

    // Zero wait states: back-to-back reads after reset, ready pulses 3 cycles apart.
    xfer(1'b1, 1'b0, 4'd0, 8'h00, 0);
    r1 = last_rdy_cyc;
    xfer(1'b1, 1'b0, 4'd15, 8'h00, 0);
    check("ready_spacing_w0", 32'(last_rdy_cyc - r1), 32'd3);

    // Write then read.
    xfer(1'b0, 1'b1, 4'd3, 8'hA5, 0);
    xfer(1'b0, 1'b0, 4'd3, 8'h00, 0);
    repeat (3) @(negedge clk);
    check("rdata_idle_hold", 32'(rdata2), 32'h0A5);

    // Inputs change after acceptance; latched command wins.
    xfer(1'b0, 1'b1, 4'd5, 8'h3C, 1);
    xfer(1'b0, 1'b0, 4'd5, 8'h00, 0);
    xfer(1'b0, 1'b0, 4'd6, 8'h00, 0);

    // Protocol violation mid-transfer.
    p0 = perr_cnt[0];
    xfer(1'b0, 1'b1, 4'd7, 8'h42, 2);
    repeat (2) @(negedge clk);
    #1;
    check("prot_err_pulses", 32'(perr_cnt[0] - p0), 32'd1);
    xfer(1'b0, 1'b0, 4'd7, 8'h00, 0);

    // Reset during BUSY of a write: abandoned, memory cleared.
    xfer(1'b0, 1'b0, 4'd3, 8'h00, 0);
    @(negedge clk);
    @(negedge clk);
    sel = 1'b0; wr_rd = 1'b1; addr = 4'd2; wdata = 8'h77; valid = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("busy_before_rst", 32'(busy2), 32'd1);
    res = 1'b0;
    #1;
    check("rst_mid_ready", 32'(ready2), 32'd0);
    check("rst_mid_busy", 32'(busy2), 32'd0);
    check("rst_mid_rdata", 32'(rdata2), 32'd0);
    valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      model[0][i] = 8'h00;
      model[1][i] = 8'h00;
    end
    last_rd = '{8'h00, 8'h00};
    @(negedge clk) res = 1'b1;
    xfer(1'b0, 1'b0, 4'd2, 8'h00, 0);
    xfer(1'b0, 1'b0, 4'd3, 8'h00, 0);

    // Full sweep.
    repeat (2) @(negedge clk);
    #1;
    r0 = rdy_cnt[0];
    p0 = perr_cnt[0];
    for (int i = 0; i < 16; i++) xfer(1'b0, 1'b1, 4'(i), 8'(i) ^ 8'h5A, 0);
    for (int i = 0; i < 16; i++) xfer(1'b0, 1'b0, 4'(i), 8'h00, 0);
    repeat (2) @(negedge clk);
    #1;
    check("sweep_ready_count", 32'(rdy_cnt[0] - r0), 32'd32);
    check("sweep_prot_err", 32'(perr_cnt[0] - p0), 32'd0);
    check("w0_prot_err", 32'(perr_cnt[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
